// File: rtl/fp_flag_retire_fifo.sv
// In-order retire buffer behind the fp32 divider: a first-word-fall-through FIFO of
// {result, exception flags} with a sticky fflags register fed by retiring entries.
module fp_flag_retire_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_y,
  input  logic [4:0]                   in_flags,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_y,
  output logic [4:0]                   out_flags,
  output logic [4:0]                   fflags,
  input  logic                         fflags_wr,
  input  logic [4:0]                   fflags_wdata,
  input  logic                         fflags_clr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] y;
    logic [4:0]  flags;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic [4:0]      fflags_q, fflags_d;

  logic            push, pop;
  logic [4:0]      popped_flags;
  entry_t          head;

  // in_ready deliberately ignores out_ready: a full buffer never accepts,
  // even when the head retires on the same edge.
  assign in_ready  = (count_q < CW'(DEPTH)) && !rst;
  assign out_valid = (count_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign out_y     = out_valid ? head.y     : '0;
  assign out_flags = out_valid ? head.flags : '0;
  assign fflags    = fflags_q;
  assign count     = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    popped_flags = '0;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + PW'(1);
      popped_flags = head.flags;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Software write beats clear; a retiring entry's flags are never lost.
    if (fflags_wr)       fflags_d = fflags_wdata | popped_flags;
    else if (fflags_clr) fflags_d = popped_flags;
    else                 fflags_d = fflags_q | popped_flags;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fflags_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
    end
  end

  // NOTE: storage has no reset; validity comes solely from count_q, so stale
  // contents are never observable and the array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{y: in_y, flags: in_flags};
  end

endmodule

// File: tb/tb_fp_flag_retire_fifo.sv
// Randomised and directed bench for fp_flag_retire_fifo: a queue-based reference
// model tracks buffered entries and the sticky flags, checked every cycle.
module tb_fp_flag_retire_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_y;
  logic [4:0]    in_flags;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_y;
  logic [4:0]    out_flags;
  logic [4:0]    fflags;
  logic          fflags_wr;
  logic [4:0]    fflags_wdata;
  logic          fflags_clr;
  logic [CW-1:0] count;

  fp_flag_retire_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_flags(out_flags),
    .fflags(fflags), .fflags_wr(fflags_wr), .fflags_wdata(fflags_wdata),
    .fflags_clr(fflags_clr), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    logic [4:0]  flags;
  } exp_t;

  exp_t       sb[$];
  logic [4:0] exp_ff;
  int         n_cmp  = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard push: record every accepted result just after the sampling point.
  always @(negedge clk) begin
    #1;
    if (!rst && in_valid && in_ready) sb.push_back('{y: in_y, flags: in_flags});
  end

  // Monitor: compares DUT state against the model and retires the head on a pop.
  always @(negedge clk) begin
    logic [4:0] popped;
    exp_t       head;
    if (rst) begin
      sb.delete();
      exp_ff = '0;
      check("rst_count", 64'(count), 64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_fflags", 64'(fflags), 64'(0));
      check("rst_out_y", 64'(out_y), 64'(0));
    end else begin
      check("count", 64'(count), 64'(sb.size()));
      check("in_ready", 64'(in_ready), 64'(sb.size() < DEPTH));
      check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      check("fflags", 64'(fflags), 64'(exp_ff));
      popped = '0;
      if (sb.size() != 0) begin
        head = sb[0];
        check("head_y", 64'(out_y), 64'(head.y));
        check("head_flags", 64'(out_flags), 64'(head.flags));
        if (out_ready) begin
          popped = head.flags;
          void'(sb.pop_front());
        end
      end else begin
        check("idle_out_y", 64'(out_y), 64'(0));
        check("idle_out_flags", 64'(out_flags), 64'(0));
      end
      if (fflags_wr)       exp_ff = fflags_wdata | popped;
      else if (fflags_clr) exp_ff = popped;
      else                 exp_ff = exp_ff | popped;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_y = '0; in_flags = '0; out_ready = 1'b0;
    fflags_wr = 1'b0; fflags_wdata = '0; fflags_clr = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 4 * DEPTH && count != 0; i++) step();
    check("drain_done", 64'(count), 64'(0));
    out_ready = 1'b0;
  endtask

  task automatic clear_flags();
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
  endtask

  initial begin
    logic [31:0] fill_y [5];
    fill_y[0] = 32'h3F80_0000; fill_y[1] = 32'h4000_0000; fill_y[2] = 32'h4040_0000;
    fill_y[3] = 32'h4080_0000; fill_y[4] = 32'h40A0_0000;
    idle_inputs();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Fill with out_ready low; the fifth push must be refused.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_y = fill_y[i]; in_flags = '0;
      step();
      if (i == 3) begin
        check("fill_count", 64'(count), 64'(DEPTH));
        check("fill_in_ready", 64'(in_ready), 64'(0));
      end
    end
    check("fifth_ignored_count", 64'(count), 64'(DEPTH));
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH) step();
    check("drained_count", 64'(count), 64'(0));
    out_ready = 1'b0;

    // Flag accumulation happens only at retirement.
    clear_flags();
    in_valid = 1'b1; in_y = 32'h3F80_0000; in_flags = 5'b00001; step();
    in_y = 32'h7F80_0000; in_flags = 5'b01000; step();
    in_valid = 1'b0;
    check("acc_after_push", 64'(fflags), 64'(0));
    out_ready = 1'b1; step();
    check("acc_after_a", 64'(fflags), 64'(5'b00001));
    step();
    check("acc_after_b", 64'(fflags), 64'(5'b01001));
    out_ready = 1'b0;

    // Write and clear collide with a pop: write wins, popped flags still merge.
    in_valid = 1'b1; in_y = 32'h1234_5678; in_flags = 5'b00100; step();
    in_valid = 1'b0;
    fflags_wr = 1'b1; fflags_wdata = 5'b00011; step();
    check("coll_preset", 64'(fflags), 64'(5'b00011));
    fflags_wdata = 5'b10000; fflags_clr = 1'b1; out_ready = 1'b1; step();
    check("coll_result", 64'(fflags), 64'(5'b10100));
    fflags_wr = 1'b0; fflags_clr = 1'b0; out_ready = 1'b0;

    // Full with a simultaneous pop: no push that cycle, push accepted next cycle.
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_y = 32'hC000_0000 + 32'(i); in_flags = 5'(i); step();
    end
    check("full_count", 64'(count), 64'(DEPTH));
    in_y = 32'hDEAD_BEEF; in_flags = 5'b00010; out_ready = 1'b1; step();
    check("full_pop_only", 64'(count), 64'(DEPTH - 1));
    out_ready = 1'b0; step();
    check("full_push_next", 64'(count), 64'(DEPTH));
    in_valid = 1'b0;
    drain();

    // Asynchronous reset between edges discards three poisoned entries.
    clear_flags();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_y = 32'hFFFF_0000 + 32'(i); in_flags = 5'b11111; step();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_count", 64'(count), 64'(0));
    check("async_rst_out_valid", 64'(out_valid), 64'(0));
    check("async_rst_fflags", 64'(fflags), 64'(0));
    check("async_rst_in_ready", 64'(in_ready), 64'(0));
    repeat (2) step();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check("post_rst_no_stale", 64'(out_valid), 64'(0));
    check("post_rst_fflags", 64'(fflags), 64'(0));

    // Wrap-around at full rate with random back-pressure; only pops touch fflags.
    for (int i = 0; i < 3 * DEPTH * 4; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_y      = $urandom;
      in_flags  = 5'($urandom);
      out_ready = $urandom_range(0, 1) == 1;
      step();
    end
    drain();

    // Random mix including software writes and clears.
    for (int i = 0; i < 200; i++) begin
      in_valid     = ($urandom_range(0, 2) != 0);
      in_y         = $urandom;
      in_flags     = 5'($urandom);
      out_ready    = ($urandom_range(0, 2) != 0);
      fflags_wr    = ($urandom_range(0, 15) == 0);
      fflags_wdata = 5'($urandom);
      fflags_clr   = ($urandom_range(0, 15) == 0);
      step();
    end
    fflags_wr = 1'b0; fflags_clr = 1'b0;
    drain();
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
